mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single main-memory block interface between two 2-way set-associative caches (e.g. instruction and data). It accepts block-level read and write requests from each cache, in the same request/valid handshake the caches use, and issues them one at a time to main memory. It registers the winning request, waits for the memory acknowledge, and returns the block to the owning cache. A watchdog aborts transactions that memory never acknowledges.

## Interface
- ADDRESS_WIDTH, 8, block address width (low 2 bits are always 0 from the caches; passed through unchanged)
- BLOCK_SIZE, 128, block data width in bits
- TIMEOUT, 255, max cycles in ISSUE before abort; 0 disables the watchdog; counter is 8 bits wide

Ports (clock and reset first):
- clk  input  1  single clock; all logic is on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  cache_req from cache 0 / 1; held high until serviced
- write0 / write1  input  1  cache_write: 1 = block writeback, 0 = block refill
- addr0 / addr1  input  ADDRESS_WIDTH  cache_addr
- wdata0 / wdata1  input  BLOCK_SIZE  cache_wdata (don't-care on reads)
- valid0 / valid1  output  1  mem_valid back to cache 0 / 1; one-cycle pulse
- rdata0 / rdata1  output  BLOCK_SIZE  mem_data back to cache 0 / 1; valid while validN=1
- err0 / err1  output  1  pulses together with validN when the transaction timed out
- mem_req  output  1  request to main memory
- mem_write  output  1  1 = write mem_wdata to mem_addr
- mem_addr  output  ADDRESS_WIDTH  registered address of the granted request
- mem_wdata  output  BLOCK_SIZE  registered write data
- mem_ack  input  1  one-cycle completion pulse from memory
- mem_rdata  input  BLOCK_SIZE  read block, valid while mem_ack=1
- gnt  output  2  one-hot owner; nonzero only in ISSUE and RESP
- busy  output  1  1 in any state other than IDLE

## Operation
- States: IDLE, ISSUE, RESP, GAP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one reqN=1, grant N.
  - If both are pending, grant the requester that is not last_grant.
  - On grant, capture writeN, addrN and wdataN into mem_write, mem_addr and mem_wdata; set gnt, set last_grant=N, clear the watchdog counter, and go to ISSUE.
- **ISSUE**
  - mem_req=1 and mem_* fields are stable. Requester inputs are ignored, and a changing reqN has no effect.
  - mem_ack=1: latch mem_rdata into rdataN and go to RESP.
  - If the counter reaches TIMEOUT (TIMEOUT≠0) without an ack, set rdataN=0 and errN=1, then go to RESP.
  - When mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and errN=0.
- **RESP**
  - mem_req=0, validN=1 for exactly this cycle; errN as set in ISSUE.
  - Go to GAP.
- **GAP**
  - One dead cycle that gives the cache time to drop or replace its request. Requests are ignored.
  - gnt=0. Go to IDLE.
- mem_ack outside ISSUE is ignored, and no validN is generated.
- A cache's writeback followed by its refill are two independent transactions. The other requester may be serviced between them under round-robin.
- rdataN holds its last value outside RESP. It is updated only for the granted N.

## Timing
- **Reset values:** valid0/1=0, err0/1=0, rdata0/1=0, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, gnt=0, busy=0, state=IDLE, last_grant=1 (so cache 0 wins the first tie), counter=0.
- **Reset mid-transaction:** all outputs go to reset values immediately (asynchronous). The in-flight memory transaction is abandoned and no validN is produced.
- **Request latency:** reqN sampled high in IDLE at edge t → mem_req=1 from cycle t+1.
- **Response latency:** mem_ack sampled high at edge k → validN=1 and mem_req=0 during cycle k+1; GAP at k+2; IDLE at k+3. The earliest next mem_req is at k+4.
- **Timeout:** with mem_ack never asserted, validN/errN pulse TIMEOUT+1 cycles after mem_req rises.
- **Throughput:** minimum 4 cycles per transaction with zero-wait memory (ack in the first ISSUE cycle).
- No combinational path from any input to any output; every output is registered.

## Test plan
- **Single refill:** req0=1, write0=0, addr0=8'h24; memory acks after 3 cycles with rdata=128'hA5..A5 → mem_addr=8'h24 and mem_write=0 one cycle after the request; valid0 pulses one cycle with rdata0=A5..A5; valid1 stays 0.
- **Simultaneous after reset:** req0=req1=1 → cache 0 is served first (gnt=01), then cache 1 (gnt=10). The next tie with both still requesting goes to cache 0 again, confirming alternation.
- **Writeback then refill:** cache 1 issues write1=1, addr1=8'hE0, wdata=128'h1234, then a read of 8'h40 after valid1, while req0 is held. Required:
  - memory sees write E0/1234 first;
  - cache 0's transaction is served next;
  - cache 1's read 8'h40 is served last.
- **Timeout:** TIMEOUT=4, req0=1, mem_ack is never asserted → valid0=1, err0=1, rdata0=0 in the 5th cycle after mem_req rises; mem_req=0 the same cycle.
- **Ack/timeout collision and stray ack:**
  - mem_ack arriving exactly at counter=TIMEOUT → err0=0 and data is delivered.
  - mem_ack pulsed while in IDLE → no validN.
- **Async reset during ISSUE:** rst_n pulled low mid-wait → mem_req, gnt and busy drop before the next clock edge. After release, a stale mem_ack produces no validN and state is IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between two caches.
// One transaction in flight at a time: IDLE -> ISSUE -> RESP -> GAP -> IDLE.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BLOCK_SIZE    = 128,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     write0,
  input  logic                     write1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [BLOCK_SIZE-1:0]    wdata0,
  input  logic [BLOCK_SIZE-1:0]    wdata1,
  output logic                     valid0,
  output logic                     valid1,
  output logic [BLOCK_SIZE-1:0]    rdata0,
  output logic [BLOCK_SIZE-1:0]    rdata1,
  output logic                     err0,
  output logic                     err1,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [BLOCK_SIZE-1:0]    mem_rdata,
  output logic [1:0]               gnt,
  output logic                     busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_GAP} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
  localparam bit         LP_WDOG_EN = (TIMEOUT != 0);

  state_t                   r_state, w_state_next;
  logic                     r_last_grant, w_grant_next;
  logic [7:0]               r_cnt, w_cnt_next;
  logic                     r_err, w_err_next;
  logic                     r_mem_write;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [BLOCK_SIZE-1:0]    r_mem_wdata;
  logic [BLOCK_SIZE-1:0]    r_rdata0, r_rdata1;
  logic                     w_capture, w_ack_take, w_timeout;
  logic                     w_sel_write;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [BLOCK_SIZE-1:0]    w_sel_wdata;
  logic [BLOCK_SIZE-1:0]    w_ret_data;
  logic                     w_in_resp, w_owned;

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_last_grant;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_capture    = 1'b0;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          w_grant_next = (req0 && req1) ? ~r_last_grant : req1;
          w_capture    = 1'b1;
          w_cnt_next   = 8'd0;
          w_err_next   = 1'b0;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          w_ack_take   = 1'b1;
          w_err_next   = 1'b0;
          w_state_next = ST_RESP;
        end else if (LP_WDOG_EN && (r_cnt == LP_TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = ST_RESP;
        end else if (LP_WDOG_EN) begin
          w_cnt_next   = r_cnt + 8'd1;
        end
      end
      ST_RESP: w_state_next = ST_GAP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_sel_write = w_grant_next ? write1 : write0;
  assign w_sel_addr  = w_grant_next ? addr1  : addr0;
  assign w_sel_wdata = w_grant_next ? wdata1 : wdata0;
  assign w_ret_data  = w_ack_take ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_err        <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_grant_next;
      r_cnt        <= w_cnt_next;
      r_err        <= w_err_next;
      if (w_capture) begin
        r_mem_write <= w_sel_write;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      // Only the owner's return register changes; the other keeps its last block.
      if (w_ack_take || w_timeout) begin
        if (r_last_grant) r_rdata1 <= w_ret_data;
        else              r_rdata0 <= w_ret_data;
      end
    end
  end

  assign w_in_resp = (r_state == ST_RESP);
  assign w_owned   = (r_state == ST_ISSUE) || w_in_resp;

  assign valid0    = w_in_resp && !r_last_grant;
  assign valid1    = w_in_resp &&  r_last_grant;
  assign err0      = w_in_resp && !r_last_grant && r_err;
  assign err1      = w_in_resp &&  r_last_grant && r_err;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_req   = (r_state == ST_ISSUE);
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign gnt       = w_owned ? (r_last_grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory requests
// and cache responses; independent monitors pop and compare them.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int BS = 128;
  localparam int TO = 4;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [BS-1:0] wdata; } mem_t;
  typedef struct { int delay; logic [BS-1:0] data; } plan_t;
  typedef struct { logic port; logic err; logic [BS-1:0] data; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, write0 = 0, write1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [BS-1:0] wdata0 = '0, wdata1 = '0;
  logic          valid0, valid1, err0, err1;
  logic [BS-1:0] rdata0, rdata1;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [BS-1:0] mem_wdata;
  logic          model_ack = 0, stray_ack = 0;
  logic [BS-1:0] model_rdata = '0;
  logic          w_mem_ack;
  logic [1:0]    gnt;
  logic          busy;

  assign w_mem_ack = model_ack | stray_ack;

  mem_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .valid0(valid0), .valid1(valid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(w_mem_ack), .mem_rdata(model_rdata),
    .gnt(gnt), .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int n_valid = 0;
  mem_t  exp_mem[$];
  plan_t plan[$];
  rsp_t  exp_rsp[$];

  task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: event did not occur within the cycle budget", name);
  endtask

  task automatic wait_mem_req(input string name, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_req) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) bound_fail(name);
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid0 || valid1) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) bound_fail(name);
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_valid0"}, 128'(valid0), 128'h0);
    chk({p, "_valid1"}, 128'(valid1), 128'h0);
    chk({p, "_err"}, 128'({err0, err1}), 128'h0);
    chk({p, "_mem_req"}, 128'(mem_req), 128'h0);
    chk({p, "_mem_write"}, 128'(mem_write), 128'h0);
    chk({p, "_mem_addr"}, 128'(mem_addr), 128'h0);
    chk({p, "_mem_wdata"}, mem_wdata, 128'h0);
    chk({p, "_gnt"}, 128'(gnt), 128'h0);
    chk({p, "_busy"}, 128'(busy), 128'h0);
    chk({p, "_rdata0"}, rdata0, 128'h0);
    chk({p, "_rdata1"}, rdata1, 128'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Memory side: check each issued request and answer it according to the plan.
  initial begin
    logic  prev_req;
    mem_t  em;
    plan_t pl;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) begin
          bound_fail("mem_unexpected_request");
        end else begin
          em = exp_mem.pop_front();
          chk("mem_write", 128'(mem_write), 128'(em.wr));
          chk("mem_addr", 128'(mem_addr), 128'(em.addr));
          if (em.wr) chk("mem_wdata", mem_wdata, em.wdata);
        end
        if (plan.size() != 0) begin
          pl = plan.pop_front();
          if (pl.delay >= 0) begin
            repeat (pl.delay) @(negedge clk);
            model_ack   = 1'b1;
            model_rdata = pl.data;
            @(negedge clk);
            model_ack   = 1'b0;
          end
        end
      end
      prev_req = mem_req;
    end
  end

  // Cache side: every valid pulse must match the oldest expected response.
  initial begin
    rsp_t er;
    logic port;
    logic err;
    logic [BS-1:0] data;
    forever begin
      @(negedge clk);
      if ((err0 && !valid0) || (err1 && !valid1)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL err_without_valid: err0=%0b err1=%0b valid0=%0b valid1=%0b",
                 err0, err1, valid0, valid1);
      end
      if (valid0 || valid1) begin
        n_valid++;
        port = valid1;
        err  = port ? err1 : err0;
        data = port ? rdata1 : rdata0;
        $display("[TB] rsp port=%0d err=%0b data=%h", port, err, data);
        chk("rsp_single_valid", 128'(valid0 & valid1), 128'h0);
        if (exp_rsp.size() == 0) begin
          bound_fail("rsp_unexpected_valid");
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_port", 128'(port), 128'(er.port));
          chk("rsp_err", 128'(err), 128'(er.err));
          chk("rsp_data", data, er.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    int nv;
    logic [7:0] b;
    logic [1:0] exp_gnt[3];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Single refill, ack after 3 ISSUE cycles
    exp_mem.push_back('{1'b0, 8'h24, 128'h0});
    plan.push_back('{3, {16{8'hA5}}});
    exp_rsp.push_back('{1'b0, 1'b0, {16{8'hA5}}});
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'h24; wdata0 = 128'hDEAD;
    wait_mem_req("t1_mem_req", cyc);
    chk("t1_req_latency", 128'(cyc), 128'd1);
    chk("t1_gnt", 128'(gnt), 128'(2'b01));
    chk("t1_busy", 128'(busy), 128'h1);
    wait_valid("t1_valid", cyc);
    chk("t1_rsp_latency", 128'(cyc), 128'd4);
    chk("t1_mem_req_low", 128'(mem_req), 128'h0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous requests after reset alternate 0,1,0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = 8'h10 + 8'(i);
      exp_mem.push_back('{1'b0, (exp_gnt[i] == 2'b01) ? 8'h10 : 8'h20, 128'h0});
      plan.push_back('{0, {16{b}}});
      exp_rsp.push_back('{exp_gnt[i][1], 1'b0, {16{b}}});
    end
    req0 = 1'b1; addr0 = 8'h10; req1 = 1'b1; write1 = 1'b0; addr1 = 8'h20;
    for (int i = 0; i < 3; i++) begin
      wait_mem_req("t2_mem_req", cyc);
      chk("t2_gnt", 128'(gnt), 128'(exp_gnt[i]));
      wait_valid("t2_valid", cyc);
      chk("t2_zero_wait_latency", 128'(cyc), 128'd1);
      if (i == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Writeback then refill from cache 1 with cache 0 interleaved
    exp_mem.push_back('{1'b1, 8'hE0, 128'h1234});
    exp_mem.push_back('{1'b0, 8'h30, 128'h0});
    exp_mem.push_back('{1'b0, 8'h40, 128'h0});
    plan.push_back('{1, 128'hBEEF});
    plan.push_back('{2, {16{8'h5A}}});
    plan.push_back('{0, {16{8'h3C}}});
    exp_rsp.push_back('{1'b1, 1'b0, 128'hBEEF});
    exp_rsp.push_back('{1'b0, 1'b0, {16{8'h5A}}});
    exp_rsp.push_back('{1'b1, 1'b0, {16{8'h3C}}});
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'h30;
    req1 = 1'b1; write1 = 1'b1; addr1 = 8'hE0; wdata1 = 128'h1234;
    wait_mem_req("t3_wb_req", cyc);
    chk("t3_wb_gnt", 128'(gnt), 128'(2'b10));
    wait_valid("t3_wb_valid", cyc);
    write1 = 1'b0; addr1 = 8'h40; wdata1 = '0;
    wait_mem_req("t3_c0_req", cyc);
    chk("t3_c0_gnt", 128'(gnt), 128'(2'b01));
    wait_valid("t3_c0_valid", cyc);
    req0 = 1'b0;
    wait_mem_req("t3_rf_req", cyc);
    chk("t3_rf_gnt", 128'(gnt), 128'(2'b10));
    wait_valid("t3_rf_valid", cyc);
    chk("t3_rdata0_held", rdata0, {16{8'h5A}});
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout: no ack ever
    exp_mem.push_back('{1'b0, 8'h50, 128'h0});
    plan.push_back('{-1, 128'h0});
    exp_rsp.push_back('{1'b0, 1'b1, 128'h0});
    req0 = 1'b1; addr0 = 8'h50;
    wait_mem_req("t4_mem_req", cyc);
    wait_valid("t4_valid", cyc);
    chk("t4_timeout_latency", 128'(cyc), 128'(TO + 1));
    chk("t4_mem_req_low", 128'(mem_req), 128'h0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Ack in the same cycle the counter reaches TIMEOUT
    exp_mem.push_back('{1'b0, 8'h60, 128'h0});
    plan.push_back('{TO, {16{8'hC3}}});
    exp_rsp.push_back('{1'b0, 1'b0, {16{8'hC3}}});
    req0 = 1'b1; addr0 = 8'h60;
    wait_mem_req("t5_mem_req", cyc);
    wait_valid("t5_valid", cyc);
    chk("t5_collision_latency", 128'(cyc), 128'(TO + 1));
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Stray ack in IDLE
    nv = n_valid;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_stray_no_valid", 128'(n_valid), 128'(nv));
    chk("t5_stray_busy", 128'(busy), 128'h0);

    // Asynchronous reset while waiting in ISSUE
    exp_mem.push_back('{1'b0, 8'h70, 128'h0});
    plan.push_back('{-1, 128'h0});
    req1 = 1'b1; write1 = 1'b0; addr1 = 8'h70;
    wait_mem_req("t6_mem_req", cyc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_mem_req", 128'(mem_req), 128'h0);
    chk("t6_async_gnt", 128'(gnt), 128'h0);
    chk("t6_async_busy", 128'(busy), 128'h0);
    chk("t6_async_rdata0", rdata0, 128'h0);
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    nv = n_valid;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_stale_ack_no_valid", 128'(n_valid), 128'(nv));
    chk("t6_idle_busy", 128'(busy), 128'h0);

    chk("end_mem_queue_empty", 128'(exp_mem.size()), 128'h0);
    chk("end_rsp_queue_empty", 128'(exp_rsp.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
